// File: rtl/sa_drain_requant.sv
// Drain stage for the 8x8 systolic array: captures a tile of accumulators, requantizes
// each to OW bits (shift, round half up, saturate) and streams it out one row per beat.
// Build option: define SA_DRAIN_RELU_EN to clamp negative results to 0 before saturation.
`timescale 1ns/1ps

module sa_rq_lane #(
  parameter int YW = 19,
  parameter int OW = 8
) (
  input  logic [YW-1:0] i_y,
  input  logic [4:0]    i_sh,
  output logic [OW-1:0] o_q
);
  localparam logic signed [YW:0] QMAX = (YW+1)'((1 << (OW-1)) - 1);
  localparam logic signed [YW:0] QMIN = ~QMAX;

  // One guard bit keeps the rounding add from overflowing at the positive extreme.
  logic signed [YW:0] w_ext, w_rnd, w_sum, w_shf, w_clp;

  assign w_ext = {i_y[YW-1], i_y};
  assign w_rnd = (i_sh == 5'd0) ? '0 : ((YW+1)'(1) << (i_sh - 5'd1));
  assign w_sum = w_ext + w_rnd;
  assign w_shf = w_sum >>> i_sh;

`ifdef SA_DRAIN_RELU_EN
  assign w_clp = w_shf[YW] ? '0 : w_shf;
`else
  assign w_clp = w_shf;
`endif

  assign o_q = (w_clp > QMAX) ? QMAX[OW-1:0] :
               (w_clp < QMIN) ? QMIN[OW-1:0] : w_clp[OW-1:0];
endmodule

module sa_drain_requant #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int YW   = 19,
  parameter int OW   = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [ROWS*COLS*YW-1:0]   Y_IN,
  input  logic                      Y_VALID,
  input  logic [4:0]                SHIFT,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [COLS*OW-1:0]        OUT_DATA,
  output logic [$clog2(ROWS)-1:0]   OUT_ROW,
  output logic                      OUT_LAST,
  output logic                      BUSY,
  output logic                      OVERRUN,
  input  logic                      OVR_CLR
);
  localparam int         RW     = $clog2(ROWS);
  localparam logic [4:0] SH_MAX = 5'(YW-1);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                           r_state, w_state_nxt;
  logic [ROWS-1:0][COLS-1:0][YW-1:0] r_buf, w_tile_in;
  logic [4:0]                       r_shift, w_shift_in, w_src_sh;
  logic [RW-1:0]                    r_out_row, w_row_nxt;
  logic [COLS*OW-1:0]               r_out_data;
  logic                             r_out_last, r_ovr;
  logic                             w_valid, w_hs, w_last_hs, w_cap, w_drop, w_adv;
  logic [COLS-1:0][YW-1:0]          w_src;
  logic [COLS-1:0][OW-1:0]          w_q;

  assign w_tile_in  = Y_IN;
  assign w_shift_in = (SHIFT > SH_MAX) ? SH_MAX : SHIFT;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Y_VALID) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_hs && !Y_VALID) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A capture is legal when idle or when the last row leaves this very cycle.
  always_comb begin
    w_valid   = (r_state == S_DRAIN);
    w_hs      = w_valid && OUT_READY;
    w_last_hs = w_hs && r_out_last;
    w_adv     = w_hs && !r_out_last;
    w_cap     = Y_VALID && (!w_valid || w_last_hs);
    w_drop    = Y_VALID && w_valid && !w_last_hs;
  end

  // Row 0 is requantized straight from Y_IN on capture to meet the one-cycle latency.
  assign w_row_nxt = (r_out_row == RW'(ROWS-1)) ? '0 : r_out_row + 1'b1;
  assign w_src     = w_cap ? w_tile_in[0] : r_buf[w_row_nxt];
  assign w_src_sh  = w_cap ? w_shift_in : r_shift;

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    sa_rq_lane #(.YW(YW), .OW(OW)) u_lane (
      .i_y  (w_src[c]),
      .i_sh (w_src_sh),
      .o_q  (w_q[c])
    );
  end

  always_ff @(posedge CLK) begin
    if (w_cap) begin
      r_buf   <= w_tile_in;
      r_shift <= w_shift_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_data <= '0;
      r_out_row  <= '0;
      r_out_last <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (w_cap || w_adv) begin
        r_out_data <= w_q;
        r_out_row  <= w_cap ? '0 : w_row_nxt;
        r_out_last <= w_cap ? 1'b0 : (w_row_nxt == RW'(ROWS-1));
      end else if (w_last_hs) begin
        r_out_last <= 1'b0;
      end
      if (w_drop)       r_ovr <= 1'b1;
      else if (OVR_CLR) r_ovr <= 1'b0;
    end
  end

  assign OUT_VALID = w_valid;
  assign BUSY      = w_valid;
  assign OUT_DATA  = r_out_data;
  assign OUT_ROW   = r_out_row;
  assign OUT_LAST  = r_out_last;
  assign OVERRUN   = r_ovr;
endmodule
